// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the four-requester divider arbiter.
// Holds the FSM encoding, response error codes and operand widths.
package div_arbiter_pkg;

  localparam int N_REQ      = 4;
  localparam int DIVISOR_W  = 16;
  localparam int DIVIDEND_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_DIV0    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } rsp_err_t;

  // Zero divisor: all-ones quotient, or the untouched dividend as the remainder.
  function automatic logic [DIVIDEND_W-1:0] div0Result(input logic mode,
                                                       input logic [DIVIDEND_W-1:0] dividend);
    return mode ? dividend : '1;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Round-robin picker: the first active request at or after the pointer wins.
// Purely combinational; the grant is one-hot, or all zero when nothing is requested.
module rr_pick
  import div_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [1:0]       idx_o
);

  logic [1:0] cand;
  logic       found;

  // Walk from the farthest offset down so the closest requester overwrites last.
  always_comb begin
    cand  = ptr_i;
    found = 1'b0;
    idx_o = ptr_i;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + 2'(k);
      if (req_i[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
    grant_o = '0;
    if (found) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Arbitrates four requesters onto one shared divider, one operation at a time.
// Zero divisors are answered locally; a stalled divider is reported as a timeout.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_mode,
  input  logic [N_REQ*DIVISOR_W-1:0]    req_divisor,
  input  logic [N_REQ*DIVIDEND_W-1:0]   req_dividend,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [DIVIDEND_W-1:0]         rsp_result,
  output logic [1:0]                    rsp_err,
  output logic                          div_valid_in,
  output logic                          div_mode,
  output logic [DIVISOR_W-1:0]          div_divisor,
  output logic [DIVIDEND_W-1:0]         div_dividend,
  input  logic                          div_busy,
  input  logic                          div_valid_out,
  input  logic [DIVIDEND_W-1:0]         div_result
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                 state_q;
  logic [1:0]             rrPtr_q;
  logic [1:0]             rrPtr_d;
  logic [1:0]             owner_q;
  logic [7:0]             timeoutCnt_q;
  logic [7:0]             timeoutCnt_d;
  logic                   mode_q;
  logic [DIVISOR_W-1:0]   divisor_q;
  logic [DIVIDEND_W-1:0]  dividend_q;
  logic                   divValidIn_q;
  logic [N_REQ-1:0]       rspValid_q;
  logic [DIVIDEND_W-1:0]  rspResult_q;
  rsp_err_t               rspErr_q;

  logic [N_REQ-1:0]       pickGrant;
  logic [1:0]             pickIdx;
  logic                   selMode;
  logic [DIVISOR_W-1:0]   selDivisor;
  logic [DIVIDEND_W-1:0]  selDividend;
  logic [N_REQ-1:0]       ownerOneHot;

  rr_pick u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (rrPtr_q),
    .grant_o (pickGrant),
    .idx_o   (pickIdx)
  );

  assign selMode     = req_mode[pickIdx];
  assign selDivisor  = req_divisor[{pickIdx, 4'b0000} +: DIVISOR_W];
  assign selDividend = req_dividend[{pickIdx, 5'b00000} +: DIVIDEND_W];

  assign rrPtr_d      = owner_q + 2'd1;
  assign timeoutCnt_d = timeoutCnt_q + 8'd1;

  always_comb begin
    ownerOneHot          = '0;
    ownerOneHot[owner_q] = 1'b1;
  end

  // The grant has to land in the same cycle the request is seen, so it stays combinational.
  assign req_ready    = (state_q == IDLE) ? pickGrant : '0;
  assign rsp_valid    = rspValid_q;
  assign rsp_result   = rspResult_q;
  assign rsp_err      = rspErr_q;
  assign div_valid_in = divValidIn_q;
  assign div_mode     = mode_q;
  assign div_divisor  = divisor_q;
  assign div_dividend = dividend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rrPtr_q      <= '0;
      owner_q      <= '0;
      timeoutCnt_q <= '0;
      mode_q       <= 1'b0;
      divisor_q    <= '0;
      dividend_q   <= '0;
      divValidIn_q <= 1'b0;
      rspValid_q   <= '0;
      rspResult_q  <= '0;
      rspErr_q     <= ERR_OK;
    end else begin
      rspValid_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            owner_q    <= pickIdx;
            mode_q     <= selMode;
            divisor_q  <= selDivisor;
            dividend_q <= selDividend;
            if (selDivisor == '0) begin
              rspResult_q <= div0Result(selMode, selDividend);
              rspErr_q    <= ERR_DIV0;
              rspValid_q  <= pickGrant;
              state_q     <= RESP;
            end else begin
              divValidIn_q <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!div_busy) begin
            divValidIn_q <= 1'b0;
            timeoutCnt_q <= '0;
            state_q      <= WAIT;
          end
        end
        // A result arriving on the last counted cycle still beats the timeout.
        WAIT: begin
          if (div_valid_out) begin
            rspResult_q <= div_result;
            rspErr_q    <= ERR_OK;
            rspValid_q  <= ownerOneHot;
            state_q     <= RESP;
          end else if (timeoutCnt_q == TIMEOUT_LAST) begin
            rspResult_q <= '0;
            rspErr_q    <= ERR_TIMEOUT;
            rspValid_q  <= ownerOneHot;
            state_q     <= RESP;
          end else begin
            timeoutCnt_q <= timeoutCnt_d;
          end
        end
        RESP: begin
          rrPtr_q <= rrPtr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: a divider model plus a scoreboard that predicts grants
// and responses from the arbitration rules, driven by a vector table, corner sequences and random traffic.
module tb_div_arbiter;

  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req_valid;
  logic [3:0]    req_mode;
  logic [63:0]   req_divisor;
  logic [127:0]  req_dividend;
  logic [3:0]    req_ready;
  logic [3:0]    rsp_valid;
  logic [31:0]   rsp_result;
  logic [1:0]    rsp_err;
  logic          div_valid_in;
  logic          div_mode;
  logic [15:0]   div_divisor;
  logic [31:0]   div_dividend;
  logic          div_busy = 1'b0;
  logic          div_valid_out = 1'b0;
  logic [31:0]   div_result = '0;

  div_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_mode      (req_mode),
    .req_divisor   (req_divisor),
    .req_dividend  (req_dividend),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .rsp_err       (rsp_err),
    .div_valid_in  (div_valid_in),
    .div_mode      (div_mode),
    .div_divisor   (div_divisor),
    .div_dividend  (div_dividend),
    .div_busy      (div_busy),
    .div_valid_out (div_valid_out),
    .div_result    (div_result)
  );

  always #5 clk = ~clk;

  int nVec  = 0;
  int nFail = 0;

  // scoreboard state: what the arbiter should be doing, in transaction terms
  bit          refBusy    = 0;
  int          refPtr     = 0;
  int          opOwner    = 0;
  logic        opMode     = 0;
  logic [15:0] opDvs      = '0;
  logic [31:0] opDvd      = '0;
  bit          opZero     = 0;
  bit          opAccepted = 0;
  int          acceptAge  = 0;
  int          busyAge    = 0;

  // divider model knobs and state
  bit          hangMode   = 0;
  int          mLatency   = 0;
  int          mStall     = 0;
  bit          mInFlight  = 0;
  int          mCountdown = 0;
  logic [31:0] mRes       = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    nVec++;
    nFail++;
    $display("[TB] FAIL %s: wait expired, got no event, required one", name);
  endtask

  function automatic int refPick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Scoreboard first (sees DUT outputs settled since the rising edge), then the divider model.
  always @(negedge clk) begin
    int          g;
    logic        expRsp;
    logic [31:0] expRes;
    logic [1:0]  expErr;
    if (reset) begin
      refBusy = 0;
      refPtr  = 0;
    end else if (!refBusy) begin
      check("rspIdle", rsp_valid, 0);
      check("issueIdle", div_valid_in, 0);
      g = refPick(req_valid, refPtr);
      if (g < 0) begin
        check("noGrant", req_ready, 0);
      end else begin
        check("grant", req_ready, 64'(1) << g);
        opOwner    = g;
        opMode     = req_mode[g];
        opDvs      = req_divisor[g*16 +: 16];
        opDvd      = req_dividend[g*32 +: 32];
        opZero     = (opDvs == 0);
        opAccepted = 0;
        acceptAge  = 0;
        busyAge    = 0;
        refBusy    = 1;
      end
    end else begin
      busyAge++;
      if (opAccepted) acceptAge++;
      check("grantBusy", req_ready, 0);
      check("divMode", div_mode, opMode);
      check("divDivisor", div_divisor, opDvs);
      check("divDividend", div_dividend, opDvd);
      if (opZero || opAccepted) check("issueQuiet", div_valid_in, 0);
      if (opZero)        expRsp = (busyAge == 1);
      else if (hangMode) expRsp = opAccepted && (acceptAge == TO + 1);
      else               expRsp = opAccepted && div_valid_out;
      if (expRsp) begin
        if (opZero) begin
          expRes = opMode ? opDvd : 32'hFFFF_FFFF;
          expErr = 2'b01;
        end else if (hangMode) begin
          expRes = 0;
          expErr = 2'b10;
        end else begin
          expRes = opMode ? opDvd % {16'd0, opDvs} : opDvd / {16'd0, opDvs};
          expErr = 2'b00;
        end
        check("rspValid", rsp_valid, 64'(1) << opOwner);
        check("rspResult", rsp_result, expRes);
        check("rspErr", rsp_err, expErr);
        refPtr  = (opOwner + 1) % 4;
        refBusy = 0;
      end else begin
        check("rspQuiet", rsp_valid, 0);
      end
      if (busyAge > 400) begin
        failNow("opStuck");
        refBusy = 0;
      end
    end

    div_valid_out = 1'b0;
    if (mInFlight) begin
      div_busy = 1'b1;
      if (!hangMode) begin
        if (mCountdown == 0) begin
          div_valid_out = 1'b1;
          div_result    = mRes;
          mInFlight     = 0;
          div_busy      = 1'b0;
        end else begin
          mCountdown--;
        end
      end
    end else if (div_valid_in === 1'b1) begin
      if (mStall > 0) begin
        div_busy = 1'b1;
        mStall--;
      end else begin
        div_busy   = 1'b0;
        if (div_divisor == 0) mRes = 0;
        else mRes = div_mode ? div_dividend % {16'd0, div_divisor} : div_dividend / {16'd0, div_divisor};
        mInFlight  = 1;
        mCountdown = mLatency;
        if (refBusy) begin
          opAccepted = 1;
          acceptAge  = 0;
        end
      end
    end else begin
      div_busy = 1'b0;
    end
  end

  typedef struct {
    int          idx;
    logic        mode;
    logic [15:0] dvs;
    logic [31:0] dvd;
    logic [31:0] expRes;
    logic [1:0]  expErr;
  } vec_t;

  vec_t vecs[8];

  task automatic stepToDrive;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic mode, input logic [15:0] dvs,
                               input logic [31:0] dvd);
    req_mode[idx]            = mode;
    req_divisor[idx*16 +: 16] = dvs;
    req_dividend[idx*32 +: 32] = dvd;
    req_valid[idx]           = 1'b1;
  endtask

  task automatic checkOutput(input logic [3:0] rv, input logic [31:0] res, input logic [1:0] err,
                             input int expIdx, input logic [31:0] expRes, input logic [1:0] expErr);
    check("outOwner", rv, 64'(1) << expIdx);
    check("outResult", res, expRes);
    check("outErr", err, expErr);
  endtask

  task automatic waitGrant(output logic [3:0] g);
    g = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        g = req_ready;
        break;
      end
    end
    if (g == 0) failNow("grantWait");
    stepToDrive();
  endtask

  task automatic waitRsp(output logic [3:0] rv, output logic [31:0] res, output logic [1:0] err);
    rv  = '0;
    res = '0;
    err = '0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin
        rv  = rsp_valid;
        res = rsp_result;
        err = rsp_err;
        break;
      end
    end
    if (rv == 0) failNow("rspWait");
    stepToDrive();
  endtask

  task automatic pulseReset;
    reset = 1'b1;
    stepToDrive();
    reset = 1'b0;
  endtask

  task automatic checkResetState;
    @(negedge clk);
    check("rstReqReady", req_ready, 0);
    check("rstRspValid", rsp_valid, 0);
    check("rstRspResult", rsp_result, 0);
    check("rstRspErr", rsp_err, 0);
    check("rstDivValidIn", div_valid_in, 0);
    check("rstDivMode", div_mode, 0);
    check("rstDivDivisor", div_divisor, 0);
    check("rstDivDividend", div_dividend, 0);
    stepToDrive();
  endtask

  initial begin
    logic [3:0]  g;
    logic [3:0]  rv;
    logic [31:0] res;
    logic [1:0]  err;
    int          order[5];

    vecs[0] = '{0, 1'b0, 16'd5,      32'd17,          32'd3,           2'b00};
    vecs[1] = '{2, 1'b1, 16'd5,      32'd17,          32'd2,           2'b00};
    vecs[2] = '{1, 1'b0, 16'd0,      32'd100,         32'hFFFF_FFFF,   2'b01};
    vecs[3] = '{3, 1'b1, 16'd0,      32'h1234_5678,   32'h1234_5678,   2'b01};
    vecs[4] = '{1, 1'b0, 16'd1,      32'hFFFF_FFFF,   32'hFFFF_FFFF,   2'b00};
    vecs[5] = '{2, 1'b0, 16'hFFFF,   32'hFFFF_FFFF,   32'h0001_0001,   2'b00};
    vecs[6] = '{3, 1'b1, 16'd7,      32'd3,           32'd3,           2'b00};
    vecs[7] = '{0, 1'b0, 16'd7,      32'd3,           32'd0,           2'b00};
    order   = '{0, 1, 2, 3, 0};

    reset        = 1'b1;
    req_valid    = '0;
    req_mode     = '0;
    req_divisor  = '0;
    req_dividend = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkResetState();

    // table of single-requester operations
    for (int i = 0; i < 8; i++) begin
      mLatency = i % 4;
      mStall   = i % 3;
      applyStimulus(vecs[i].idx, vecs[i].mode, vecs[i].dvs, vecs[i].dvd);
      waitGrant(g);
      check("tblGrant", g, 64'(1) << vecs[i].idx);
      req_valid = '0;
      waitRsp(rv, res, err);
      checkOutput(rv, res, err, vecs[i].idx, vecs[i].expRes, vecs[i].expErr);
    end

    // all four requesting from reset release: strict rotation
    pulseReset();
    mLatency = 1;
    mStall   = 0;
    for (int r = 0; r < 4; r++) applyStimulus(r, 1'b0, 16'(r + 2), 32'(100 + r));
    for (int k = 0; k < 5; k++) begin
      waitGrant(g);
      check("rotGrant", g, 64'(1) << order[k]);
      waitRsp(rv, res, err);
      checkOutput(rv, res, err, order[k], 32'((100 + order[k]) / (order[k] + 2)), 2'b00);
    end
    req_valid = '0;

    // divider accepts and then goes silent: timeout response
    hangMode = 1;
    applyStimulus(1, 1'b0, 16'd9, 32'd50);
    waitGrant(g);
    req_valid = '0;
    waitRsp(rv, res, err);
    checkOutput(rv, res, err, 1, 32'd0, 2'b10);
    hangMode   = 0;
    mInFlight  = 0;
    div_busy   = 1'b0;

    // reset while waiting on the divider, then a late result that must be dropped
    mLatency = 5;
    applyStimulus(3, 1'b1, 16'd7, 32'd30);
    waitGrant(g);
    req_valid = '0;
    for (int n = 0; n < 20 && !mInFlight; n++) stepToDrive();
    stepToDrive();
    pulseReset();
    checkResetState();
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("staleRsp", rsp_valid, 0);
    end
    stepToDrive();
    mLatency = 0;
    for (int r = 0; r < 4; r++) applyStimulus(r, 1'b1, 16'(r + 3), 32'(40 + r));
    waitGrant(g);
    check("postRstGrant", g, 4'b0001);
    req_valid = '0;
    waitRsp(rv, res, err);
    checkOutput(rv, res, err, 0, 32'd1, 2'b00);

    // random traffic; the scoreboard checks every grant and response
    for (int it = 0; it < 40; it++) begin
      mLatency = $urandom_range(0, 5);
      mStall   = $urandom_range(0, 3);
      for (int r = 0; r < 4; r++) begin
        req_mode[r]             = 1'($urandom_range(0, 1));
        req_divisor[r*16 +: 16] = ($urandom_range(0, 4) == 0) ? 16'd0 :
                                  (16'($urandom) >> $urandom_range(0, 15));
        req_dividend[r*32 +: 32] = 32'($urandom);
      end
      req_valid = 4'($urandom_range(1, 15));
      waitGrant(g);
      req_valid = req_valid & ~g;
      if ($urandom_range(0, 1) == 1) req_valid = req_valid & 4'($urandom);
      waitRsp(rv, res, err);
      check("rndOwner", rv, g);
      req_valid = '0;
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, required one before the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
